// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg -- shared types and helpers for the fetch-stage program counter.
//
// Contents:
//   pc_sel_t    : which source the PC takes at the next edge.
//   PC_MAX_W    : widest PC the sign-extending adder supports.
//   pc_add_sext : base + sign_extend(offset[width-1:0]), modulo 2^PC_MAX_W.
// -----------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_HOLD   = 3'd5
  } pc_sel_t;

  localparam int unsigned PC_MAX_W = 64;

  // Sign-extends the low 'width' bits of offset to PC_MAX_W bits and adds it
  // to base. The caller keeps only the low PC bits, which gives modulo-2^PC_W
  // wrap in both directions. A mask is used instead of a variable bit index so
  // the same function serves every PC width.
  function automatic logic [PC_MAX_W-1:0] pc_add_sext(
    input logic [PC_MAX_W-1:0] base,
    input logic [PC_MAX_W-1:0] offset,
    input int unsigned         width
  );
    logic [PC_MAX_W-1:0] mask;
    logic [PC_MAX_W-1:0] shifted;
    logic [PC_MAX_W-1:0] ext;
    mask    = (64'd1 << width) - 64'd1;
    shifted = offset >> (width - 32'd1);
    if (shifted[0]) begin
      ext = offset | ~mask;
    end else begin
      ext = offset & mask;
    end
    return base + ext;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras -- circular return-address stack (LIFO).
//
// A push onto a full stack overwrites the oldest entry: the top pointer still
// advances and the count saturates at RAS_DEPTH. A pop on an empty stack is
// ignored. push and pop are never asserted together by the parent.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   push, push_data  : write push_data as the new top entry
//   pop              : discard the top entry
//   top_data         : current top entry (registered storage, read muxed)
//   count            : valid entries, 0..RAS_DEPTH
//   full, empty      : registered flags, always consistent with count
// -----------------------------------------------------------------------------
module pc_ras #(
  parameter  int unsigned PC_W      = 8,
  parameter  int unsigned RAS_DEPTH = 4,
  localparam int unsigned PTR_W     = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  push_data,
  output logic [PC_W-1:0]  top_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PC_W-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // Next-state for storage, top pointer, count and flags.
  always_comb begin
    mem_d   = mem_q;
    top_d   = top_q;
    count_d = count_q;
    if (push) begin
      // Pointer wraps naturally (power-of-two depth); on a full stack this
      // lands on the oldest entry and overwrites it.
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = push_data;
      if (full_q) begin
        count_d = count_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && !empty_q) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end else begin
      top_d   = top_q;
      count_d = count_q;
    end
    full_d  = (count_d == CNT_W'(RAS_DEPTH));
    empty_d = (count_d == {CNT_W{1'b0}});
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Entry storage; contents are meaningless after reset, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top_data = mem_q[top_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- parametrised fetch-stage program counter with return-address
// stack.
//
// Update priority per edge: rst > stall > ret_en > call_en > jump_en >
// branch_en > sequential. Lower-priority requests in the same cycle are
// dropped. A return with an empty stack behaves as a sequential step.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   stall              : hold PC and stack this cycle
//   branch_en/offset   : relative branch, pc + 1 + signed offset
//   jump_en/target     : absolute jump (target also used by call)
//   call_en            : push pc + 1, go to jump_target
//   ret_en             : pop top entry into PC
//   pc                 : registered fetch address
//   pc_next            : combinational value pc takes at the next edge
//   ras_count/empty/full : stack occupancy (registered)
//   ras_err            : sticky over/underflow flag, only with PC_RAS_ERR_EN
//
// Build option: define PC_RAS_ERR_EN to add the ras_err output.
// -----------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch_en,
  input  logic [PC_W-1:0]            branch_offset,
  input  logic                       jump_en,
  input  logic [PC_W-1:0]            jump_target,
  input  logic                       call_en,
  input  logic                       ret_en,
  output logic [PC_W-1:0]            pc,
  output logic [PC_W-1:0]            pc_next,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full
`ifdef PC_RAS_ERR_EN
  ,
  output logic                       ras_err
`endif
);

  pc_sel_t             sel_s;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     pc_plus1_s;
  logic [PC_W-1:0]     pc_branch_s;
  logic [PC_MAX_W-1:0] branch_wide_s;
  logic [PC_W-1:0]     ras_top_s;
  logic                ras_push_s;
  logic                ras_pop_s;

  assign pc_plus1_s    = pc_q + PC_W'(1);
  assign branch_wide_s = pc_add_sext(PC_MAX_W'(pc_plus1_s), PC_MAX_W'(branch_offset), PC_W);
  assign pc_branch_s   = branch_wide_s[PC_W-1:0];

  // Priority select; a return with nothing on the stack falls back to
  // sequential so the stack is left untouched.
  always_comb begin
    sel_s = PC_SEQ;
    if (stall) begin
      sel_s = PC_HOLD;
    end else if (ret_en) begin
      if (ras_empty) begin
        sel_s = PC_SEQ;
      end else begin
        sel_s = PC_RET;
      end
    end else if (call_en) begin
      sel_s = PC_CALL;
    end else if (jump_en) begin
      sel_s = PC_JUMP;
    end else if (branch_en) begin
      sel_s = PC_BRANCH;
    end else begin
      sel_s = PC_SEQ;
    end
  end

  // Next-PC mux; reset overrides everything so pc_next matches what the
  // register will actually load.
  always_comb begin
    pc_d = pc_plus1_s;
    if (rst) begin
      pc_d = RESET_PC;
    end else begin
      case (sel_s)
        PC_HOLD:          pc_d = pc_q;
        PC_RET:           pc_d = ras_top_s;
        PC_CALL, PC_JUMP: pc_d = jump_target;
        PC_BRANCH:        pc_d = pc_branch_s;
        PC_SEQ:           pc_d = pc_plus1_s;
        default:          pc_d = pc_plus1_s;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign ras_push_s = !rst && (sel_s == PC_CALL);
  assign ras_pop_s  = !rst && (sel_s == PC_RET);

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (pc_plus1_s),
    .top_data  (ras_top_s),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  assign pc      = pc_q;
  assign pc_next = pc_d;

`ifdef PC_RAS_ERR_EN
  logic err_q, err_d;
  logic underflow_s;
  logic overflow_s;

  // A return always wins arbitration when not stalled, so underflow is any
  // unstalled ret_en on an empty stack; overflow needs the call to win.
  assign underflow_s = !stall && ret_en && ras_empty;
  assign overflow_s  = (sel_s == PC_CALL) && ras_full;

  // Sticky error accumulation.
  always_comb begin
    err_d = err_q;
    if (underflow_s || overflow_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ras_err = err_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit (PC_W=8, RAS_DEPTH=4,
// RESET_PC=0x10). Directed scenarios followed by randomized cycles, all
// compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_pc_unit;

  localparam int unsigned PC_W      = 8;
  localparam int          RAS_DEPTH = 4;
  localparam logic [7:0]  RESET_PC  = 8'h10;

  logic       clk = 1'b0;
  logic       rst, stall, branch_en, jump_en, call_en, ret_en;
  logic [7:0] branch_offset, jump_target;
  logic [7:0] pc, pc_next;
  logic [2:0] ras_count;
  logic       ras_empty, ras_full;
`ifdef PC_RAS_ERR_EN
  logic       ras_err;
`endif

  always #5 clk = ~clk;

  pc_unit #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .pc            (pc),
    .pc_next       (pc_next),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
`ifdef PC_RAS_ERR_EN
    ,
    .ras_err       (ras_err)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_pc   = 0;
  int m_next = 0;
  int m_stack[$];
  bit m_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decide this edge's outcome from the current inputs using the plain rules.
  task automatic model_step();
    int off;
    if (rst) begin
      m_next = int'(RESET_PC);
      m_stack.delete();
      m_err = 1'b0;
    end else if (stall) begin
      m_next = m_pc;
    end else if (ret_en) begin
      if (m_stack.size() > 0) begin
        m_next = m_stack.pop_back();
      end else begin
        m_next = (m_pc + 1) % 256;
        m_err  = 1'b1;
      end
    end else if (call_en) begin
      if (m_stack.size() == RAS_DEPTH) begin
        void'(m_stack.pop_front());
        m_err = 1'b1;
      end
      m_stack.push_back((m_pc + 1) % 256);
      m_next = int'(jump_target);
    end else if (jump_en) begin
      m_next = int'(jump_target);
    end else if (branch_en) begin
      off = int'(branch_offset);
      if (off >= 128) off = off - 256;
      m_next = (((m_pc + 1 + off) % 256) + 256) % 256;
    end else begin
      m_next = (m_pc + 1) % 256;
    end
  endtask

  // One clock: check pc_next before the edge, then registered state after.
  task automatic cycle(input string tag);
    #1;
    model_step();
    check_eq({tag, ".pc_next"}, 32'(pc_next), 32'(m_next));
    @(posedge clk);
    #1;
    m_pc = m_next;
    check_eq({tag, ".pc"},    32'(pc),        32'(m_pc));
    check_eq({tag, ".count"}, 32'(ras_count), 32'(m_stack.size()));
    check_eq({tag, ".empty"}, 32'(ras_empty), 32'(m_stack.size() == 0));
    check_eq({tag, ".full"},  32'(ras_full),  32'(m_stack.size() == RAS_DEPTH));
`ifdef PC_RAS_ERR_EN
    check_eq({tag, ".err"},   32'(ras_err),   32'(m_err));
`endif
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0;
    branch_offset = 8'h00; jump_target = 8'h00;
  endtask

  task automatic do_jump(input logic [7:0] t);
    idle(); jump_en = 1'b1; jump_target = t; cycle("jmp");
  endtask

  logic [7:0] held_pc;
  logic [7:0] exp_ret [5];

  initial begin
    idle();
    // Reset then sequential run.
    rst = 1'b1;
    cycle("reset");
    check_eq("reset_pc", 32'(pc), 32'h10);
    check_eq("reset_empty", 32'(ras_empty), 32'h1);
    idle();
    repeat (3) cycle("seq");
    check_eq("seq_pc", 32'(pc), 32'h13);

    // Signed branches and wrap.
    do_jump(8'h20);
    idle(); branch_en = 1'b1; branch_offset = 8'hFC; cycle("br_neg");
    check_eq("br_neg_val", 32'(pc), 32'h1D);
    do_jump(8'h20);
    idle(); branch_en = 1'b1; branch_offset = 8'h05; cycle("br_pos");
    check_eq("br_pos_val", 32'(pc), 32'h26);
    idle(); branch_en = 1'b1; branch_offset = 8'hFF; cycle("br_self");
    check_eq("br_self_val", 32'(pc), 32'h26);
    do_jump(8'hFF);
    idle(); cycle("wrap");
    check_eq("wrap_val", 32'(pc), 32'h00);

    // Jump beats branch.
    idle(); jump_en = 1'b1; branch_en = 1'b1; jump_target = 8'h80; branch_offset = 8'h10;
    cycle("jmp_vs_br");
    check_eq("jmp_vs_br_val", 32'(pc), 32'h80);

    // Call / return.
    do_jump(8'h30);
    idle(); call_en = 1'b1; jump_target = 8'h90; cycle("call");
    check_eq("call_val", 32'(pc), 32'h90);
    check_eq("call_cnt", 32'(ras_count), 32'h1);
    idle(); cycle("seq"); cycle("seq");
    idle(); ret_en = 1'b1; cycle("ret");
    check_eq("ret_val", 32'(pc), 32'h31);
    check_eq("ret_cnt", 32'(ras_count), 32'h0);

    // Nested calls overflow the stack, then returns drain and underflow.
    do_jump(8'h40);
    for (int i = 0; i < 5; i++) begin
      idle(); call_en = 1'b1; jump_target = 8'h41 + 8'(i); cycle("ncall");
    end
    check_eq("ovf_full", 32'(ras_full), 32'h1);
    check_eq("ovf_cnt", 32'(ras_count), 32'h4);
    exp_ret[0] = 8'h45; exp_ret[1] = 8'h44; exp_ret[2] = 8'h43;
    exp_ret[3] = 8'h42; exp_ret[4] = 8'h43;
    for (int i = 0; i < 5; i++) begin
      idle(); ret_en = 1'b1; cycle("nret");
      check_eq("nret_val", 32'(pc), 32'(exp_ret[i]));
    end
`ifdef PC_RAS_ERR_EN
    check_eq("err_set", 32'(ras_err), 32'h1);
`endif

    // Stall with a call held: nothing moves.
    idle(); cycle("seq");
    held_pc = pc;
    idle(); stall = 1'b1; call_en = 1'b1; jump_target = 8'hA0;
    cycle("stall"); cycle("stall");
    check_eq("stall_pc", 32'(pc), 32'(held_pc));
    check_eq("stall_cnt", 32'(ras_count), 32'h0);

    // Reset with a return in flight.
    idle(); call_en = 1'b1; jump_target = 8'h55; cycle("call");
    idle(); rst = 1'b1; ret_en = 1'b1; cycle("rst_ret");
    check_eq("rst_ret_pc", 32'(pc), 32'h10);
    check_eq("rst_ret_cnt", 32'(ras_count), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      stall         = ($urandom_range(0, 7) == 0);
      ret_en        = ($urandom_range(0, 3) == 0);
      call_en       = ($urandom_range(0, 3) == 0);
      jump_en       = ($urandom_range(0, 3) == 0);
      branch_en     = ($urandom_range(0, 2) == 0);
      branch_offset = 8'($urandom_range(0, 255));
      jump_target   = 8'($urandom_range(0, 255));
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
